// File: rtl/meter_channel_arbiter.sv
// Round-robin arbiter sharing one bar-array display writer between NUM_CH meter
// converters, with one-entry capture buffers per channel and a frame_done pulse.
module meter_channel_arbiter #(
    parameter  int NUM_CH = 2,
    parameter  int WIDTH  = 32,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [NUM_CH*WIDTH-1:0] in_array,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [CH_W-1:0]         o_channel,
    output logic [WIDTH-1:0]        o_array,
    output logic                    frame_done
);

    // Handshakes: a transfer happens on an edge where valid && ready; valid never
    // waits on ready, and o_valid/o_array/o_channel stay frozen while o_ready is low.

    localparam logic [CH_W:0] LP_NUM = (CH_W+1)'(NUM_CH);

    logic [NUM_CH-1:0] r_buf_full;
    logic [WIDTH-1:0]  r_buf [NUM_CH];
    logic [CH_W-1:0]   r_rr_ptr;
    logic [NUM_CH-1:0] r_seen;

    logic              w_free;
    logic              w_any;
    logic              w_grant;
    logic [CH_W-1:0]   w_sel;
    logic [CH_W-1:0]   w_rr_next;
    logic [NUM_CH-1:0] w_take;
    logic              w_out_hs;
    logic [NUM_CH-1:0] w_seen_next;

    assign in_ready = ~r_buf_full;
    assign w_free   = !o_valid || o_ready;
    assign w_grant  = w_free && w_any;
    assign w_out_hs = o_valid && o_ready;
    assign w_take   = w_grant ? (NUM_CH'(1) << w_sel) : '0;
    assign w_seen_next = r_seen | (NUM_CH'(1) << o_channel);

    // First full buffer at or after rr_ptr, wrapping modulo NUM_CH.
    always_comb begin
        logic [CH_W:0] v_idx;
        logic [CH_W:0] v_next;
        w_any  = 1'b0;
        w_sel  = '0;
        v_idx  = '0;
        v_next = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            v_idx = {1'b0, r_rr_ptr} + (CH_W+1)'(k);
            if (v_idx >= LP_NUM) begin
                v_idx = v_idx - LP_NUM;
            end
            if (!w_any && r_buf_full[v_idx[CH_W-1:0]]) begin
                w_any = 1'b1;
                w_sel = v_idx[CH_W-1:0];
            end
        end
        v_next = {1'b0, w_sel} + (CH_W+1)'(1);
        if (v_next >= LP_NUM) begin
            v_next = '0;
        end
        w_rr_next = v_next[CH_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf_full <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_buf[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                // A buffer is either drained or filled on an edge, never both.
                if (w_take[c]) begin
                    r_buf_full[c] <= 1'b0;
                end else if (in_valid[c] && !r_buf_full[c]) begin
                    r_buf_full[c] <= 1'b1;
                    r_buf[c]      <= in_array[c*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_valid   <= 1'b0;
            o_array   <= '0;
            o_channel <= '0;
            r_rr_ptr  <= '0;
        end else if (w_grant) begin
            o_valid   <= 1'b1;
            o_array   <= r_buf[w_sel];
            o_channel <= w_sel;
            r_rr_ptr  <= w_rr_next;
        end else if (o_ready) begin
            o_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seen     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (w_out_hs) begin
                if (&w_seen_next) begin
                    frame_done <= 1'b1;
                    r_seen     <= '0;
                end else begin
                    r_seen <= w_seen_next;
                end
            end
        end
    end

endmodule
